// File: rtl/dpram_test_pkg.sv
// Shared types and helpers for the dual-port RAM march tester.
package dpram_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_UP,
    RD_UP,
    RD_UP_DRAIN,
    WR_DN,
    RD_DN,
    RD_DN_DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] PATTERN_DEFAULT = 8'hA5;

  // Test word for an address; callers truncate the result to their data width.
  function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic invert,
                                           input logic [31:0] pattern = 32'(PATTERN_DEFAULT));
    logic [31:0] w;
    w = addr ^ pattern;
    return invert ? ~w : w;
  endfunction

endpackage

// File: rtl/dpram_march_tester_read_checker.sv
// One-stage expected/address pipe aligned with the RAM read latency, plus the
// comparator and first-failure latch.
module dpram_read_checker
  import dpram_test_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic                  failed;

  // The failed flag masks the stale pipe entry captured on the abort edge.
  assign mismatch = valid_q && !failed && (q_b != exp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      exp_q     <= '0;
      failed    <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      valid_q <= rd_valid;
      addr_q  <= rd_addr;
      exp_q   <= rd_exp;
      if (clear) begin
        failed    <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (mismatch) begin
        failed    <= 1'b1;
        fail_addr <= addr_q;
        fail_data <= q_b;
      end
    end
  end

endmodule

// File: rtl/dpram_march_tester.sv
// Four-phase march test initiator: port A writes, port B reads, first
// mismatch aborts the run and is reported.
module dpram_march_tester
  import dpram_test_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(PATTERN_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  we_b,
  input  logic [DATA_WIDTH-1:0] q_b
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic [ADDR_WIDTH-1:0] cnt_dec;
  logic                  accept;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] e_word(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic inv);
    return DATA_WIDTH'(exp_word(32'(a), inv, 32'(PATTERN)));
  endfunction

  assign cnt_inc  = cnt + 1'b1;
  assign cnt_dec  = cnt - 1'b1;
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign rd_valid = (state == RD_UP) || (state == RD_DN);
  assign rd_exp   = e_word(cnt, state == RD_DN);
  assign we_b     = 1'b0;
  assign data_b   = '0;

  dpram_read_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .rd_valid (rd_valid),
    .rd_addr  (cnt),
    .rd_exp   (rd_exp),
    .q_b      (q_b),
    .mismatch (mismatch),
    .fail_addr(fail_addr),
    .fail_data(fail_data)
  );

  // Port outputs are loaded on the same edge that moves cnt, so the bus
  // always shows the address belonging to the current cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      we_a   <= 1'b0;
      addr_a <= '0;
      data_a <= '0;
      addr_b <= '0;
    end else if (mismatch) begin
      state <= DONE;
      busy  <= 1'b0;
      done  <= 1'b1;
      pass  <= 1'b0;
      we_a  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= WR_UP;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            pass   <= 1'b0;
            we_a   <= 1'b1;
            addr_a <= '0;
            data_a <= e_word('0, 1'b0);
          end
        end
        WR_UP: begin
          if (cnt == CNT_MAX) begin
            state  <= RD_UP;
            cnt    <= '0;
            we_a   <= 1'b0;
            addr_b <= '0;
          end else begin
            cnt    <= cnt_inc;
            addr_a <= cnt_inc;
            data_a <= e_word(cnt_inc, 1'b0);
          end
        end
        RD_UP: begin
          if (cnt == CNT_MAX) begin
            state <= RD_UP_DRAIN;
          end else begin
            cnt    <= cnt_inc;
            addr_b <= cnt_inc;
          end
        end
        RD_UP_DRAIN: begin
          state  <= WR_DN;
          cnt    <= CNT_MAX;
          we_a   <= 1'b1;
          addr_a <= CNT_MAX;
          data_a <= e_word(CNT_MAX, 1'b1);
        end
        WR_DN: begin
          if (cnt == '0) begin
            state  <= RD_DN;
            cnt    <= CNT_MAX;
            we_a   <= 1'b0;
            addr_b <= CNT_MAX;
          end else begin
            cnt    <= cnt_dec;
            addr_a <= cnt_dec;
            data_a <= e_word(cnt_dec, 1'b1);
          end
        end
        RD_DN: begin
          if (cnt == '0) begin
            state <= RD_DN_DRAIN;
          end else begin
            cnt    <= cnt_dec;
            addr_b <= cnt_dec;
          end
        end
        RD_DN_DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_march_tester.sv
// Bench for dpram_march_tester: behavioural RAM with read-path fault injection
// and an arithmetic model of the march outcome.
module tb_dpram_march_tester;

  localparam logic [7:0] P = 8'hA5;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, pass;
  logic [5:0] fail_addr;
  logic [7:0] fail_data;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       we_a, we_b;
  logic [7:0] q_b;

  int checks   = 0;
  int failures = 0;

  dpram_march_tester #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(8),
    .PATTERN   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .we_a     (we_a),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .we_b     (we_b),
    .q_b      (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read and a fault applied on the read path.
  logic [7:0] mem [64];
  logic [7:0] q_reg;
  logic [5:0] rd_addr_q;
  logic       fault_on;
  logic [5:0] f_addr;
  logic [7:0] f_x, f_o, f_z;

  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    q_reg     <= mem[addr_b];
    rd_addr_q <= addr_b;
  end

  assign q_b = (fault_on && rd_addr_q == f_addr) ? (((q_reg ^ f_x) | f_o) & ~f_z) : q_reg;

  logic [46:0] all_out;
  assign all_out = {busy, done, pass, we_a, we_b, fail_addr, fail_data,
                    addr_a, addr_b, data_a, data_b};

  logic [13:0] wr_log[$];
  int          side_err = 0;

  always @(negedge clk) begin
    if (we_a) wr_log.push_back({addr_a, data_a});
    if (we_b || data_b != 8'h00) side_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of a full march given the faulted address and its masks.
  task automatic predict(input logic [5:0] fa, input logic [7:0] fx, input logic [7:0] fo,
                         input logic [7:0] fz, output logic e_pass, output logic [5:0] e_addr,
                         output logic [7:0] e_data, output int e_cyc);
    logic [7:0] e, o;
    e_pass = 1'b1; e_addr = '0; e_data = '0; e_cyc = 258;
    for (int a = 0; a < 64; a++) begin
      e = 8'(a) ^ P;
      o = (6'(a) == fa) ? (((e ^ fx) | fo) & ~fz) : e;
      if (o != e) begin
        e_pass = 1'b0; e_addr = 6'(a); e_data = o; e_cyc = 66 + a;
        return;
      end
    end
    for (int a = 63; a >= 0; a--) begin
      e = ~(8'(a) ^ P);
      o = (6'(a) == fa) ? (((e ^ fx) | fo) & ~fz) : e;
      if (o != e) begin
        e_pass = 1'b0; e_addr = 6'(a); e_data = o; e_cyc = 195 + (63 - a);
        return;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts busy cycles; optionally pulses start again at busy cycle inject_at.
  task automatic wait_done(input int inject_at, output int cyc, output logic [16:0] first,
                           output logic timeout);
    cyc = 0; timeout = 1'b1; first = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) first = {busy, done, pass, fail_addr, fail_data};
      start = (inject_at != 0 && cyc == inject_at);
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run_fault(input string tag, input logic [5:0] fa, input logic [7:0] fx,
                           input logic [7:0] fo, input logic [7:0] fz);
    logic        e_pass;
    logic [5:0]  e_addr;
    logic [7:0]  e_data;
    int          e_cyc, cyc;
    logic [16:0] first;
    logic        tmo;
    fault_on = 1'b1; f_addr = fa; f_x = fx; f_o = fo; f_z = fz;
    predict(fa, fx, fo, fz, e_pass, e_addr, e_data, e_cyc);
    pulse_start();
    wait_done(0, cyc, first, tmo);
    check({tag, "_timeout"}, 64'(tmo), 64'(0));
    check({tag, "_cycles"}, 64'(cyc), 64'(e_cyc));
    check({tag, "_result"}, {done, pass, fail_addr, fail_data}, {1'b1, e_pass, e_addr, e_data});
    fault_on = 1'b0;
  endtask

  initial begin
    int          cyc, seq_err;
    logic [16:0] first;
    logic        tmo;
    logic [5:0]  ea;
    logic [7:0]  ed;

    rst = 1'b1; start = 1'b0; fault_on = 1'b0;
    f_addr = '0; f_x = '0; f_o = '0; f_z = '0;
    #1 check("reset_outputs", 64'(all_out), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean march plus port A write sequence.
    wr_log.delete();
    pulse_start();
    wait_done(0, cyc, first, tmo);
    check("clean_busy_first", 64'(first[16]), 64'(1));
    check("clean_timeout", 64'(tmo), 64'(0));
    check("clean_cycles", 64'(cyc), 64'(258));
    check("clean_result", {done, pass, fail_addr, fail_data}, {1'b1, 1'b1, 6'h00, 8'h00});
    check("wr_count", 64'(wr_log.size()), 64'(128));
    check("wr_up_addr5", 64'(wr_log[5]), {6'h05, 8'hA0});
    check("wr_dn_first", 64'(wr_log[64]), {6'h3F, 8'h65});
    check("wr_dn_last", 64'(wr_log[127]), {6'h00, 8'h5A});
    seq_err = 0;
    for (int i = 0; i < 128; i++) begin
      ea = (i < 64) ? 6'(i) : 6'(127 - i);
      ed = (i < 64) ? (8'(ea) ^ P) : ~(8'(ea) ^ P);
      if (i >= wr_log.size() || wr_log[i] != {ea, ed}) seq_err++;
    end
    check("wr_sequence", 64'(seq_err), 64'(0));

    // Up-phase fault, then a clean restart from DONE.
    run_fault("up_fault", 6'h05, 8'h08, 8'h00, 8'h00);
    check("up_fault_lit", {pass, fail_addr, fail_data}, {1'b0, 6'h05, 8'hA8});
    pulse_start();
    wait_done(0, cyc, first, tmo);
    check("restart_cleared", 64'(first), {1'b1, 1'b0, 1'b0, 6'h00, 8'h00});
    check("restart_cycles", 64'(cyc), 64'(258));
    check("restart_pass", {done, pass}, 2'b11);

    // Down-only stuck-at-1.
    run_fault("dn_fault", 6'h3F, 8'h00, 8'h80, 8'h00);
    check("dn_fault_lit", {pass, fail_addr, fail_data}, {1'b0, 6'h3F, 8'hE5});

    // Asynchronous reset during the up read phase.
    pulse_start();
    repeat (80) @(negedge clk);
    check("pre_rst_busy", {busy, we_a}, 2'b10);
    #2 rst = 1'b1;
    #1 check("midrun_reset", 64'(all_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    wait_done(0, cyc, first, tmo);
    check("post_rst_cycles", 64'(cyc), 64'(258));
    check("post_rst_pass", {done, pass, fail_addr, fail_data}, {1'b1, 1'b1, 6'h00, 8'h00});

    // start while busy in WR_DN is ignored.
    pulse_start();
    wait_done(150, cyc, first, tmo);
    check("busy_start_cycles", 64'(cyc), 64'(258));
    check("busy_start_pass", {done, pass}, 2'b11);

    // Randomised single-address faults.
    for (int r = 0; r < 8; r++) begin
      logic [5:0] fa;
      logic [7:0] m;
      int         kind;
      fa   = 6'($urandom_range(0, 63));
      m    = 8'h01 << $urandom_range(0, 7);
      kind = $urandom_range(0, 2);
      case (kind)
        0:       run_fault($sformatf("rnd%0d_flip", r), fa, m, 8'h00, 8'h00);
        1:       run_fault($sformatf("rnd%0d_sa1", r), fa, 8'h00, m, 8'h00);
        default: run_fault($sformatf("rnd%0d_sa0", r), fa, 8'h00, 8'h00, m);
      endcase
    end

    check("port_b_quiet", 64'(side_err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
